logic_axi4_stream_demux_unit: RTL and testbench

1:2 AXI4-Stream packet demultiplexer, the distribution-side counterpart of the 2:1 stream mux unit. Routes each Rx packet to tx[0] or tx[1] according to one tdest bit sampled on the first beat. The route is held until tlast. Each output has its own registered stage, so a stalled output never corrupts the other.

---
 rtl/logic_axi4_stream_demux_pkg.sv | 10 +
 rtl/logic_axi4_stream_if.sv | 21 ++
 rtl/logic_axi4_stream_demux_stage.sv | 31 +++
 rtl/logic_axi4_stream_demux_unit.sv | 103 ++++++++++
 tb/tb_logic_axi4_stream_demux_unit.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_axi4_stream_demux_pkg.sv
// rtl/logic_axi4_stream_demux_pkg.sv - shared types for the 1:2 stream demultiplexer
package logic_axi4_stream_demux_pkg;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_LOCK_0 = 2'd1,
        FSM_LOCK_1 = 2'd2
    } fsm_t;

endpackage

// File: rtl/logic_axi4_stream_if.sv
// rtl/logic_axi4_stream_if.sv - AXI4-Stream bundle with rx (sink) and tx (source) views
interface logic_axi4_stream_if #(
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1
);
    logic [8*TDATA_BYTES-1:0] tdata;
    logic [TDATA_BYTES-1:0]   tkeep;
    logic [TDATA_BYTES-1:0]   tstrb;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic [TID_WIDTH-1:0]     tid;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic                     tlast;
    logic                     tvalid;
    logic                     tready;

    modport rx (input tdata, tkeep, tstrb, tuser, tid, tdest, tlast, tvalid, output tready);
    modport tx (output tdata, tkeep, tstrb, tuser, tid, tdest, tlast, tvalid, input tready);

endinterface

// File: rtl/logic_axi4_stream_demux_stage.sv
// rtl/logic_axi4_stream_demux_stage.sv - one registered output slot: load, hold or drain
module logic_axi4_stream_demux_stage #(
    parameter int W = 8
) (
    input  logic         aclk,
    input  logic         areset_n,
    input  logic         load,
    input  logic [W-1:0] beat,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] held
);

    // Load wins over drain so a full slot can be refilled in the cycle it empties.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (load) begin
            held <= beat;
        end
    end

endmodule

// File: rtl/logic_axi4_stream_demux_unit.sv
// rtl/logic_axi4_stream_demux_unit.sv - 1:2 packet demux routed by one tdest bit, locked until last
module logic_axi4_stream_demux_unit
    import logic_axi4_stream_demux_pkg::*;
#(
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int USE_TLAST   = 1,
    parameter int USE_TKEEP   = 1,
    parameter int USE_TSTRB   = 1,
    parameter int SELECT_BIT  = 0
) (
    input logic                 aclk,
    input logic                 areset_n,
    logic_axi4_stream_if.rx     rx,
    logic_axi4_stream_if.tx     tx [2]
);

    localparam int PW = 10 * TDATA_BYTES + TUSER_WIDTH + TID_WIDTH + TDEST_WIDTH + 1;

    fsm_t                   state;
    fsm_t                   state_next;
    logic                   sel;
    logic                   last;
    logic                   hs;
    logic [TDATA_BYTES-1:0] keep;
    logic [TDATA_BYTES-1:0] strb;
    logic [PW-1:0]          rx_beat;
    logic [PW-1:0]          held [2];
    logic [1:0]             load;
    logic [1:0]             stage_valid;
    logic [1:0]             stage_ready;

    assign last    = (USE_TLAST != 0) ? rx.tlast : 1'b1;
    assign keep    = (USE_TKEEP != 0) ? rx.tkeep : '1;
    assign strb    = (USE_TSTRB != 0) ? rx.tstrb : '1;
    // Disabled fields are folded to constants before capture, so outputs need no extra muxing.
    assign rx_beat = {rx.tdata, keep, strb, rx.tuser, rx.tid, rx.tdest, last};

    always_comb begin
        sel = rx.tdest[SELECT_BIT];
        case (state)
            FSM_LOCK_0: sel = 1'b0;
            FSM_LOCK_1: sel = 1'b1;
            default:    sel = rx.tdest[SELECT_BIT];
        endcase
    end

    // Ready looks only at the selected slot, never at rx.tvalid.
    assign rx.tready = !stage_valid[sel] || stage_ready[sel];
    assign hs        = rx.tvalid && rx.tready;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state <= FSM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FSM_IDLE: begin
                if (hs && !last) begin
                    state_next = sel ? FSM_LOCK_1 : FSM_LOCK_0;
                end
            end
            FSM_LOCK_0, FSM_LOCK_1: begin
                if (hs && last) begin
                    state_next = FSM_IDLE;
                end
            end
            default: state_next = FSM_IDLE;
        endcase
    end

    for (genvar i = 0; i < 2; i++) begin : g_out
        assign load[i]        = hs && (sel == 1'(i));
        assign stage_ready[i] = tx[i].tready;

        logic_axi4_stream_demux_stage #(
            .W (PW)
        ) u_stage (
            .aclk     (aclk),
            .areset_n (areset_n),
            .load     (load[i]),
            .beat     (rx_beat),
            .ready    (stage_ready[i]),
            .valid    (stage_valid[i]),
            .held     (held[i])
        );

        assign tx[i].tvalid = stage_valid[i];
        assign {tx[i].tdata, tx[i].tkeep, tx[i].tstrb, tx[i].tuser,
                tx[i].tid, tx[i].tdest, tx[i].tlast} = held[i];
    end

    rx_stable: assert property (@(posedge aclk) disable iff (!areset_n)
        (rx.tvalid && !rx.tready) |=> (rx.tvalid && $stable(rx_beat)));

endmodule

// File: tb/tb_logic_axi4_stream_demux_unit.sv
// tb/tb_logic_axi4_stream_demux_unit.sv - scoreboard bench for the 1:2 stream demux (tlast and no-tlast builds)
module tb_logic_axi4_stream_demux_unit;

    typedef struct packed {
        logic [7:0] data;
        logic       keep;
        logic       strb;
        logic       user;
        logic       id;
        logic       dest;
        logic       last;
    } beat_t;

    logic aclk = 1'b0;
    logic areset_n;
    always #5 aclk = ~aclk;

    // index d: 0 = tlast build, 1 = no-tlast build; index k = 2*d + output
    beat_t rx_beat  [2];
    logic  rx_valid [2];
    logic  rx_ready [2];
    beat_t tx_beat  [4];
    logic  tx_valid [4];
    logic  tx_ready [4];

    logic_axi4_stream_if rx_if [2] ();
    logic_axi4_stream_if tx_a  [2] ();
    logic_axi4_stream_if tx_b  [2] ();

    for (genvar d = 0; d < 2; d++) begin : g_rx
        assign rx_if[d].tdata  = rx_beat[d].data;
        assign rx_if[d].tkeep  = rx_beat[d].keep;
        assign rx_if[d].tstrb  = rx_beat[d].strb;
        assign rx_if[d].tuser  = rx_beat[d].user;
        assign rx_if[d].tid    = rx_beat[d].id;
        assign rx_if[d].tdest  = rx_beat[d].dest;
        assign rx_if[d].tlast  = rx_beat[d].last;
        assign rx_if[d].tvalid = rx_valid[d];
        assign rx_ready[d]     = rx_if[d].tready;
    end

    for (genvar i = 0; i < 2; i++) begin : g_tx
        assign tx_beat[i]     = {tx_a[i].tdata, tx_a[i].tkeep, tx_a[i].tstrb, tx_a[i].tuser,
                                 tx_a[i].tid, tx_a[i].tdest, tx_a[i].tlast};
        assign tx_valid[i]    = tx_a[i].tvalid;
        assign tx_a[i].tready = tx_ready[i];
        assign tx_beat[2+i]   = {tx_b[i].tdata, tx_b[i].tkeep, tx_b[i].tstrb, tx_b[i].tuser,
                                 tx_b[i].tid, tx_b[i].tdest, tx_b[i].tlast};
        assign tx_valid[2+i]  = tx_b[i].tvalid;
        assign tx_b[i].tready = tx_ready[2+i];
    end

    logic_axi4_stream_demux_unit #(.USE_TLAST(1)) u_dut_a (
        .aclk     (aclk),
        .areset_n (areset_n),
        .rx       (rx_if[0]),
        .tx       (tx_a)
    );

    logic_axi4_stream_demux_unit #(.USE_TLAST(0)) u_dut_b (
        .aclk     (aclk),
        .areset_n (areset_n),
        .rx       (rx_if[1]),
        .tx       (tx_b)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q [4][$];
    bit    in_pkt [2];
    bit    route  [2];
    int    delivered [2];
    bit    rand_ready [2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic dest, input logic last);
        beat_t b;
        b      = beat_t'(14'($urandom));
        b.dest = dest;
        b.last = last;
        return b;
    endfunction

    // Packet-level reference: a packet goes where its first beat's tdest says.
    task automatic model_accept(input int d, input beat_t b, output int k);
        beat_t e;
        bit    r;
        bit    eff_last;
        eff_last = (d == 0) ? b.last : 1'b1;
        r        = in_pkt[d] ? route[d] : b.dest;
        e        = b;
        e.last   = eff_last;
        k        = 2 * d + int'(r);
        exp_q[k].push_back(e);
        in_pkt[d] = !eff_last;
        route[d]  = r;
    endtask

    task automatic send(input int d, input beat_t b, output int stalls);
        int k;
        rx_beat[d]  = b;
        rx_valid[d] = 1'b1;
        stalls      = 0;
        #1;
        while (!rx_ready[d] && stalls < 300) begin
            @(negedge aclk);
            #1;
            stalls++;
        end
        if (!rx_ready[d]) begin
            check("rx_handshake_timeout", 0, 1);
            rx_valid[d] = 1'b0;
            return;
        end
        model_accept(d, b, k);
        @(posedge aclk);
        @(negedge aclk);
        check($sformatf("latency_k%0d", k), int'(tx_valid[k]), 1);
        rx_valid[d] = 1'b0;
    endtask

    for (genvar k = 0; k < 4; k++) begin : g_mon
        initial begin
            beat_t e;
            forever begin
                @(negedge aclk);
                #2;
                if (areset_n && tx_valid[k] && tx_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check($sformatf("unexpected_beat_k%0d", k), int'(tx_beat[k]), 0);
                    end else begin
                        e = exp_q[k].pop_front();
                        check($sformatf("beat_k%0d", k), int'(tx_beat[k]), int'(e));
                        delivered[k/2]++;
                    end
                end
            end
        end
    end

    for (genvar d = 0; d < 2; d++) begin : g_rand
        initial begin
            forever begin
                @(negedge aclk);
                if (rand_ready[d]) begin
                    tx_ready[2*d]   = 1'($urandom_range(0, 1));
                    tx_ready[2*d+1] = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        areset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rx_valid[d]   = 1'b0;
            rx_beat[d]    = '0;
            in_pkt[d]     = 1'b0;
            route[d]      = 1'b0;
            delivered[d]  = 0;
            rand_ready[d] = 1'b0;
        end
        for (int k = 0; k < 4; k++) tx_ready[k] = 1'b1;
        repeat (3) @(negedge aclk);
        for (int k = 0; k < 4; k++) check($sformatf("reset_tvalid_k%0d", k), int'(tx_valid[k]), 0);
        check("reset_rx_ready_a", int'(rx_ready[0]), 1);
        areset_n = 1'b1;
        @(negedge aclk);

        // single beats to 0, 1, 0 with no stall
        for (int j = 0; j < 3; j++) begin
            send(0, mk(logic'(j == 1), 1'b1), st);
            check("single_no_stall", st, 0);
        end

        // 4-beat packet locked to output 1 while tdest toggles, then a fresh beat to 0
        for (int j = 0; j < 4; j++) begin
            send(0, mk(logic'(j % 2 == 0), logic'(j == 3)), st);
        end
        send(0, mk(1'b0, 1'b1), st);
        check("after_lock_no_stall", st, 0);
        repeat (3) @(negedge aclk);

        // stalled output 1 blocks rx while output 0 drains its held beat
        tx_ready[0] = 1'b0;
        send(0, mk(1'b0, 1'b1), st);
        tx_ready[1] = 1'b0;
        send(0, mk(1'b1, 1'b0), st);
        fork
            begin
                send(0, mk(1'b0, 1'b0), st);
                send(0, mk(1'b0, 1'b1), st);
            end
            begin
                #1;
                check("stall_rx_ready_low", int'(rx_ready[0]), 0);
                @(negedge aclk);
                tx_ready[0] = 1'b1;
                repeat (3) @(negedge aclk);
                check("stall_tx0_drained", int'(tx_valid[0]), 0);
                check("stall_tx1_held", int'(tx_valid[1]), 1);
                tx_ready[1] = 1'b1;
            end
        join
        repeat (3) @(negedge aclk);

        // back-to-back packets, 2 beats each, second beat tdest random
        for (int j = 0; j < 4; j++) begin
            send(0, mk((j < 2) ? ((j == 0) ? 1'b0 : 1'($urandom)) : ((j == 2) ? 1'b1 : 1'($urandom)),
                       logic'(j % 2 == 1)), st);
            check("b2b_no_stall", st, 0);
        end

        // reset after beat 1 of a 3-beat packet to output 0
        send(0, mk(1'b0, 1'b0), st);
        send(0, mk(1'b1, 1'b0), st);
        #1;
        areset_n = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        in_pkt[0] = 1'b0;
        in_pkt[1] = 1'b0;
        #1;
        check("async_reset_tvalid0", int'(tx_valid[0]), 0);
        check("async_reset_tvalid1", int'(tx_valid[1]), 0);
        @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
        send(0, mk(1'b1, 1'b1), st);
        repeat (3) @(negedge aclk);

        // randomized packets with random backpressure
        rand_ready[0] = 1'b1;
        for (int j = 0; j < 40; j++) begin
            send(0, mk(1'($urandom), logic'($urandom_range(0, 2) == 0)), st);
        end
        @(negedge aclk);
        rand_ready[0] = 1'b0;
        tx_ready[0]   = 1'b1;
        tx_ready[1]   = 1'b1;

        // no-tlast build: every beat routed independently, tlast forced high
        rand_ready[1] = 1'b1;
        send(1, mk(1'b1, 1'b0), st);
        send(1, mk(1'b1, 1'($urandom)), st);
        send(1, mk(1'b0, 1'b0), st);
        @(negedge aclk);
        rand_ready[1] = 1'b0;
        tx_ready[2]   = 1'b1;
        tx_ready[3]   = 1'b1;

        repeat (10) @(negedge aclk);
        check("notlast_delivered", delivered[1], 3);
        for (int k = 0; k < 4; k++) check($sformatf("drain_k%0d", k), exp_q[k].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
